// File: rtl/uart_pkg.sv
// Shared UART subsystem definitions: pad bundle typedefs and TX arbiter defaults.
package uart_pkg;

  localparam int UART_NB_SRC    = 4;
  localparam int UART_MAX_BURST = 16;

  typedef enum logic [1:0] {
    PAD_MODE_OFF = 2'b00,
    PAD_MODE_IN  = 2'b01,
    PAD_MODE_OUT = 2'b10,
    PAD_MODE_IO  = 2'b11
  } pad_mode_e;

  typedef struct packed {
    logic tx;
    logic tx_oe;
    logic rx;
  } uart_pad_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/udma_uart_rr_sel.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping
// from NB_SRC-1 back to 0, so 'last' itself has the lowest priority.
module udma_uart_rr_sel #(
  parameter int NB_SRC = 4
) (
  input  logic [NB_SRC-1:0]         req,
  input  logic [$clog2(NB_SRC)-1:0] last,
  output logic [NB_SRC-1:0]         onehot,
  output logic [$clog2(NB_SRC)-1:0] idx
);

  localparam int IW = $clog2(NB_SRC);

  logic found;
  int   pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 1; k <= NB_SRC; k++) begin
      pos = int'(last) + k;
      if (pos >= NB_SRC) pos = pos - NB_SRC;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/udma_uart_tx_arb.sv
// Packet-level round-robin arbiter merging NB_SRC byte streams onto one UART TX path.
// Handshake: a byte moves only in a cycle where valid and ready are both high; valid never waits on ready.
module udma_uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NB_SRC    = UART_NB_SRC,
  parameter int MAX_BURST = UART_MAX_BURST
) (
  input  logic                      sys_clk_i,
  input  logic                      rstn_i,
  input  logic                      arb_en_i,
  input  logic [NB_SRC-1:0]         src_mask_i,
  input  logic [NB_SRC*8-1:0]       src_data_i,
  input  logic [NB_SRC-1:0]         src_valid_i,
  input  logic [NB_SRC-1:0]         src_last_i,
  output logic [NB_SRC-1:0]         src_ready_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(NB_SRC)-1:0] grant_id_o,
  output logic                      busy_o,
  output logic                      rel_evt_o
);

  localparam int IW = $clog2(NB_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rel_q, rel_d;
  logic [NB_SRC-1:0] req;
  logic [NB_SRC-1:0] sel_onehot;
  logic [IW-1:0]     sel_idx;
  logic [7:0]        g_data;
  logic              g_valid;
  logic              g_last;
  logic              beat;

  assign req = src_valid_i & src_mask_i;

  udma_uart_rr_sel #(
    .NB_SRC (NB_SRC)
  ) u_rr_sel (
    .req    (req),
    .last   (grant_q),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NB_SRC; i++) begin
      if (grant_q == IW'(i)) begin
        g_data  = src_data_i[i*8 +: 8];
        g_valid = src_valid_i[i];
        g_last  = src_last_i[i];
      end
    end
  end

  assign beat = (state_q == ARB_XFER) && g_valid && tx_ready_i;

  // The granted source dropping valid only stalls the packet; release needs last or a full burst.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rel_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_en_i && (|sel_onehot)) begin
          state_d = ARB_XFER;
          grant_d = sel_idx;
          cnt_d   = '0;
        end
      end
      ARB_XFER: begin
        if (beat) begin
          cnt_d = cnt_q + CW'(1);
          if (g_last || (cnt_q == CW'(MAX_BURST - 1))) begin
            state_d = ARB_IDLE;
            rel_d   = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      grant_q <= IW'(NB_SRC - 1);
      cnt_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    tx_data_o   = '0;
    tx_valid_o  = 1'b0;
    src_ready_o = '0;
    if (state_q == ARB_XFER) begin
      tx_data_o  = g_data;
      tx_valid_o = g_valid;
      for (int i = 0; i < NB_SRC; i++) begin
        src_ready_o[i] = (grant_q == IW'(i)) && tx_ready_i;
      end
    end
  end

  assign busy_o     = (state_q == ARB_XFER);
  assign grant_id_o = grant_q;
  assign rel_evt_o  = rel_q;

endmodule

// File: doc/udma_uart_tx_arb.md
UDMA_UART_TX_ARB -- requirements
Module: udma_uart_tx_arb

Interface
REQ-001 SHALL have parameter NB_SRC, default 4, giving the number of byte-stream sources (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, giving the maximum bytes per grant before forced release (1..256).
REQ-003 SHALL have port sys_clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port arb_en_i, input, 1 bit: enables new grants.
REQ-006 SHALL have port src_mask_i, input, NB_SRC bits: 1 = source eligible for grant.
REQ-007 SHALL have port src_data_i, input, NB_SRC x 8 bits: per-source byte.
REQ-008 SHALL have port src_valid_i, input, NB_SRC bits: per-source byte valid.
REQ-009 SHALL have port src_last_i, input, NB_SRC bits: per-source last byte of packet.
REQ-010 SHALL have port src_ready_o, output, NB_SRC bits: per-source byte accepted.
REQ-011 SHALL have port tx_data_o, output, 8 bits: byte to UART TX path.
REQ-012 SHALL have port tx_valid_o, output, 1 bit: tx_data_o valid.
REQ-013 SHALL have port tx_ready_i, input, 1 bit: UART TX path accepts the byte.
REQ-014 SHALL have port grant_id_o, output, $clog2(NB_SRC) bits: currently or last granted source.
REQ-015 SHALL have port busy_o, output, 1 bit: a grant is held.
REQ-016 SHALL have port rel_evt_o, output, 1 bit: one-cycle pulse on each grant release.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and XFER.
REQ-018 In IDLE, when arb_en_i=1 and (src_valid_i & src_mask_i) is nonzero, SHALL select a source round-robin, searching from (last grant + 1) mod NB_SRC upward, wrapping at NB_SRC-1 to 0.
REQ-019 The selected source SHALL be registered into grant_id_o with transition to XFER on that edge; arbitration latency is exactly 1 cycle from valid to first tx_valid_o.
REQ-020 In IDLE, tx_valid_o SHALL be 0 and src_ready_o SHALL be all-zero.
REQ-021 In XFER, the datapath SHALL be combinational: tx_data_o = src_data_i[grant], tx_valid_o = src_valid_i[grant], src_ready_o[grant] = tx_ready_i, all other src_ready_o bits 0.
REQ-022 A byte SHALL transfer only on tx_valid_o & tx_ready_i in the same cycle.
REQ-023 A beat counter, width $clog2(MAX_BURST+1), SHALL clear on grant and increment per transferred byte.
REQ-024 A grant SHALL be released (next state IDLE, rel_evt_o=1 for one cycle) on the transferring edge where src_last_i[grant]=1 or the counter reaches MAX_BURST; last takes precedence, with identical effect.
REQ-025 The granted source deasserting src_valid_i mid-packet SHALL NOT release the grant; the grant is held until REQ-024.
REQ-026 Changes to arb_en_i or src_mask_i during XFER SHALL NOT affect the current grant and SHALL take effect at the next IDLE arbitration.
REQ-027 After release, at least one IDLE cycle SHALL occur before the next grant; back-to-back packets therefore cost one bubble cycle.
REQ-028 A single eligible source SHALL be regranted repeatedly; a forced MAX_BURST release SHALL let other pending sources win before the interrupted source continues.
REQ-029 busy_o SHALL equal (state == XFER).

Reset
REQ-030 While rstn_i=0, SHALL force state IDLE, grant_id_o = NB_SRC-1 (so source 0 wins first), counter 0, tx_valid_o 0, src_ready_o 0, busy_o 0, rel_evt_o 0.
REQ-031 Reset asserted mid-XFER SHALL abort the packet immediately with no rel_evt_o pulse; the aborted source restarts arbitration after reset.

Structure
REQ-032 The NB_SRC and MAX_BURST defaults SHALL be constants in uart_pkg, alongside the existing pad typedefs.
REQ-033 The round-robin search SHALL be a combinational sub-module udma_uart_rr_sel, with inputs request vector and last grant, and outputs one-hot plus index.
REQ-034 RTL SHALL contain no latches and no clock gating.

Verification
REQ-035 Reset, then src_valid_i=4'b0001, src_last_i[0]=1, tx_ready_i=1 -> tx_valid_o on cycle 2, byte passed, rel_evt_o pulse, grant_id_o=0.
REQ-036 All four sources valid with 1-byte packets, tx_ready_i=1 -> grant order 0,1,2,3,0 with one bubble between packets.
REQ-037 Source 2 sends a 40-byte packet against MAX_BURST=16 while source 3 is waiting -> release after 16 bytes, source 3 served, source 2 resumes at byte 17, no byte lost or duplicated.
REQ-038 tx_ready_i toggled randomly and granted source src_valid_i dropped for 5 cycles mid-packet -> grant held, byte order intact, no ready on other sources.
REQ-039 src_mask_i=4'b1011 with all sources valid -> source 2 never granted; arb_en_i=0 mid-XFER -> current packet completes, no new grant.
REQ-040 rstn_i asserted during byte 3 of a packet -> outputs return to reset values asynchronously, with no rel_evt_o.
